// File: rtl/pixel_pkg.sv
// Shared definitions for the SPI pixel path: SRAM direction codes,
// write-FSM state encoding and the default SRAM word-address width.
package pixel_pkg;

  localparam logic SRAM_RW_WRITE      = 1'b1;
  localparam logic SRAM_RW_READ       = 1'b0;
  localparam int   PIX_ADDR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_WAIT  = 2'd2
  } wfsm_t;

endpackage

// File: rtl/pixel_input_writer_if.sv
// SRAM mux request/response bus. The writer drives requests as master;
// the SRAM mux answers as slave with a one-cycle sram_ready pulse.
interface pixel_input_writer_if #(
  parameter int ADDR_W = pixel_pkg::PIX_ADDR_W_DEFAULT
);
  logic              sram_start;
  logic              sram_rw;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic              sram_ready;

  modport master (
    output sram_start, sram_rw, sram_addr, sram_wdata,
    input  sram_ready
  );

  modport slave (
    input  sram_start, sram_rw, sram_addr, sram_wdata,
    output sram_ready
  );
endinterface

// File: rtl/pixel_word_fifo.sv
// Synchronous 16-bit word FIFO, depth 2^FIFO_AW. Pointers carry one extra
// bit so full and empty are distinguishable. Flush takes priority over push.
module pixel_word_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [15:0]        wdata_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [15:0]        rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   level_o
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [15:0]      mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q;
  logic [FIFO_AW:0] rd_ptr_q;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == (FIFO_AW+1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  // Pointer update: reset/flush empty the FIFO, otherwise guarded push and pop.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
      if (pop_i && !empty_o)  rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/pixel_input_writer.sv
// Pixel byte stream -> 16-bit words -> FIFO -> SRAM writes; publishes the
// end address of each completed frame.
// Optional feature macro: PIXEL_INPUT_STATS_EN adds dropped_words and
// max_fifo_level statistics outputs.
module pixel_input_writer
  import pixel_pkg::*;
#(
  parameter int                ADDR_W    = PIX_ADDR_W_DEFAULT,
  parameter int                FIFO_AW   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_frame_start,
  input  logic                pix_frame_end,
  input  logic                pix_valid,
  input  logic [7:0]          pix_data,
  pixel_input_writer_if.master sram,
  output logic [ADDR_W-1:0]   stop_addr,
  output logic                frame_done,
  output logic                overflow
`ifdef PIXEL_INPUT_STATS_EN
  ,
  output logic [15:0]         dropped_words,
  output logic [FIFO_AW:0]    max_fifo_level
`endif
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  wfsm_t             state_q, state_d;
  logic              sram_start_c;
  logic              in_frame_q, drain_q, discard_q, addr_full_q;
  logic              have_q, have_d;
  logic [7:0]        hold_q, hold_d;
  logic [ADDR_W-1:0] wr_addr_q, stop_addr_q, sram_addr_q;
  logic [15:0]       sram_wdata_q;
  logic              frame_done_q, overflow_q;

  logic              end_ok, push_req, push_drop, fifo_push, fifo_pop, addr_drop, drain_done;
  logic [15:0]       push_word, fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [FIFO_AW:0]  fifo_level;

  pixel_word_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (push_word),
    .pop_i   (fifo_pop),
    .flush_i (pix_frame_start),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Byte packer: pairs bytes high-then-low, pads an odd trailing byte at frame end.
  always_comb begin
    end_ok    = pix_frame_end && in_frame_q && !pix_frame_start;
    push_req  = 1'b0;
    push_word = '0;
    have_d    = have_q;
    hold_d    = hold_q;
    if (pix_frame_start) begin
      have_d = pix_valid;
      hold_d = pix_data;
    end else if (pix_valid && in_frame_q) begin
      if (have_q) begin
        push_req  = 1'b1;
        push_word = {hold_q, pix_data};
        have_d    = 1'b0;
      end else if (end_ok) begin
        push_req  = 1'b1;
        push_word = {pix_data, 8'h00};
      end else begin
        have_d = 1'b1;
        hold_d = pix_data;
      end
    end else if (end_ok && have_q) begin
      push_req  = 1'b1;
      push_word = {hold_q, 8'h00};
      have_d    = 1'b0;
    end
  end

  assign fifo_push  = push_req && !fifo_full;
  assign push_drop  = push_req && fifo_full;
  assign fifo_pop   = (state_q == W_IDLE) && !fifo_empty && !pix_frame_start;
  assign addr_drop  = fifo_pop && addr_full_q;
  assign drain_done = drain_q && fifo_empty && (state_q == W_IDLE) && !pix_frame_start;

  // Packer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_q <= 1'b0;
      hold_q <= '0;
    end else begin
      have_q <= have_d;
      hold_q <= hold_d;
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= W_IDLE;
    else       state_q <= state_d;
  end

  // Write FSM next state; words popped past the address limit are dropped without a request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE:  if (fifo_pop && !addr_full_q) state_d = W_ISSUE;
      W_ISSUE: state_d = W_WAIT;
      W_WAIT:  if (sram.sram_ready) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    sram_start_c = (state_q == W_ISSUE);
  end

  // Frame control, address counter, request registers and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame_q   <= 1'b0;
      drain_q      <= 1'b0;
      discard_q    <= 1'b0;
      addr_full_q  <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      stop_addr_q  <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (fifo_pop && !addr_full_q) begin
        sram_addr_q  <= wr_addr_q;
        sram_wdata_q <= fifo_rdata;
      end
      if (pix_frame_start) begin
        in_frame_q  <= 1'b1;
        drain_q     <= 1'b0;
        wr_addr_q   <= BASE_ADDR;
        addr_full_q <= 1'b0;
        overflow_q  <= 1'b0;
        // The write still in flight belongs to the old frame: let it finish
        // but do not let its completion advance the new frame's address.
        discard_q   <= (state_q == W_ISSUE) || ((state_q == W_WAIT) && !sram.sram_ready);
      end else begin
        if (end_ok) begin
          in_frame_q <= 1'b0;
          drain_q    <= 1'b1;
        end
        if (push_drop || addr_drop) overflow_q <= 1'b1;
        if ((state_q == W_WAIT) && sram.sram_ready) begin
          if (discard_q)                   discard_q   <= 1'b0;
          else if (wr_addr_q == ADDR_MAX)  addr_full_q <= 1'b1;
          else                             wr_addr_q   <= wr_addr_q + ADDR_W'(1);
        end
        if (drain_done) begin
          stop_addr_q  <= wr_addr_q;
          frame_done_q <= 1'b1;
          wr_addr_q    <= BASE_ADDR;
          addr_full_q  <= 1'b0;
          drain_q      <= 1'b0;
        end
      end
    end
  end

  assign sram.sram_start = sram_start_c;
  assign sram.sram_rw    = SRAM_RW_WRITE;
  assign sram.sram_addr  = sram_addr_q;
  assign sram.sram_wdata = sram_wdata_q;
  assign stop_addr       = stop_addr_q;
  assign frame_done      = frame_done_q;
  assign overflow        = overflow_q;

`ifdef PIXEL_INPUT_STATS_EN
  logic [15:0]      dropped_q;
  logic [FIFO_AW:0] max_level_q;
  logic [1:0]       drop_inc;
  logic [16:0]      drop_sum;

  assign drop_inc = {1'b0, push_drop} + {1'b0, addr_drop};
  assign drop_sum = {1'b0, dropped_q} + {15'b0, drop_inc};

  // Saturating drop counter and FIFO high-water mark, cleared per frame.
  always_ff @(posedge clk) begin
    if (reset || pix_frame_start) begin
      dropped_q   <= '0;
      max_level_q <= '0;
    end else begin
      dropped_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (fifo_level > max_level_q) max_level_q <= fifo_level;
    end
  end

  assign dropped_words  = dropped_q;
  assign max_fifo_level = max_level_q;
`else
  logic unused_level;
  assign unused_level = ^fifo_level;
`endif
endmodule

// File: tb/tb_pixel_input_writer.sv
module tb_pixel_input_writer;
  import pixel_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_frame_start = 1'b0;
  logic          pix_frame_end = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = 8'h00;
  logic [AW-1:0] stop_addr;
  logic          frame_done;
  logic          overflow;
`ifdef PIXEL_INPUT_STATS_EN
  logic [15:0]   dropped_words;
  logic [3:0]    max_fifo_level;
`endif

  pixel_input_writer_if #(.ADDR_W(AW)) bus ();

  pixel_input_writer #(.ADDR_W(AW), .FIFO_AW(3), .BASE_ADDR(4'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .pix_frame_start (pix_frame_start),
    .pix_frame_end   (pix_frame_end),
    .pix_valid       (pix_valid),
    .pix_data        (pix_data),
    .sram            (bus.master),
    .stop_addr       (stop_addr),
    .frame_done      (frame_done),
    .overflow        (overflow)
`ifdef PIXEL_INPUT_STATS_EN
    ,
    .dropped_words   (dropped_words),
    .max_fifo_level  (max_fifo_level)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          fd_cnt = 0;
  int          lat = 2;
  logic        stall = 1'b0;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input int a, input logic [15:0] d);
    sb.push_back(32'({1'b1, AW'(a), d}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    pix_valid = 1'b1;
    pix_data  = b;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic start_frame();
    pix_frame_start = 1'b1;
    tick();
    pix_frame_start = 1'b0;
  endtask

  task automatic end_frame();
    pix_frame_end = 1'b1;
    tick();
    pix_frame_end = 1'b0;
  endtask

  task automatic wait_done(input int exp_fd);
    for (int i = 0; i < 1000 && fd_cnt < exp_fd; i++) tick();
    check("frame_done_count", 32'(fd_cnt), 32'(exp_fd));
    check("pending_writes", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_sram_start", 32'(bus.sram_start), 32'd0);
    check("rst_sram_rw",    32'(bus.sram_rw),    32'd1);
    check("rst_sram_addr",  32'(bus.sram_addr),  32'd0);
    check("rst_sram_wdata", 32'(bus.sram_wdata), 32'd0);
    check("rst_stop_addr",  32'(stop_addr),      32'd0);
    check("rst_frame_done", 32'(frame_done),     32'd0);
    check("rst_overflow",   32'(overflow),       32'd0);
  endtask

  // SRAM mux model: ready pulse 'lat' cycles into WAIT, held off while stalled.
  initial begin
    logic pend;
    int   cnt;
    pend = 1'b0;
    cnt  = 0;
    bus.sram_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.sram_ready = 1'b0;
      if (reset) pend = 1'b0;
      else if (bus.sram_start) begin
        pend = 1'b1;
        cnt  = lat;
      end else if (pend && !stall) begin
        if (cnt == 0) begin
          bus.sram_ready = 1'b1;
          pend = 1'b0;
        end else cnt--;
      end
    end
  end

  // Write monitor and frame_done counter.
  initial begin
    logic [31:0] act;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (bus.sram_start) begin
        act = 32'({bus.sram_rw, bus.sram_addr, bus.sram_wdata});
        if (sb.size() == 0) begin
          n_cmp++;
          assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_write: observed rw/addr/data 0x%0h expected no write", act);
          end
        end else begin
          exp = sb.pop_front();
          check("write", act, exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals();

    // 1: even frame, with first-word latency check
    exp_wr(0, 16'h1122);
    exp_wr(1, 16'h3344);
    start_frame();
    send(8'h11);
    send(8'h22);
    check("latency_early", 32'(bus.sram_start), 32'd0);
    send(8'h33);
    check("latency_start", 32'(bus.sram_start), 32'd1);
    send(8'h44);
    end_frame();
    wait_done(1);
    check("t1_stop_addr", 32'(stop_addr), 32'd2);
    check("t1_overflow",  32'(overflow),  32'd0);

    // 2: odd frame, trailing byte padded
    exp_wr(0, 16'hAABB);
    exp_wr(1, 16'hCC00);
    start_frame();
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    end_frame();
    wait_done(2);
    check("t2_stop_addr", 32'(stop_addr), 32'd2);

    // 3: stalled SRAM, 20 bytes back-to-back -> 1 in flight + 8 buffered, 1 dropped
    stall = 1'b1;
    for (int k = 0; k < 9; k++) exp_wr(k, {8'(8'h30 + 2*k), 8'(8'h31 + 2*k)});
    start_frame();
    for (int i = 0; i < 20; i++) send(8'(8'h30 + i));
    end_frame();
    repeat (19) tick();
    check("t3_overflow", 32'(overflow), 32'd1);
    stall = 1'b0;
    wait_done(3);
    check("t3_stop_addr", 32'(stop_addr), 32'd9);
`ifdef PIXEL_INPUT_STATS_EN
    check("t3_dropped_words",  32'(dropped_words),  32'd1);
    check("t3_max_fifo_level", 32'(max_fifo_level), 32'd8);
`endif

    // 4: frame start while a write is waiting on the SRAM
    stall = 1'b1;
    exp_wr(0, 16'h0102);
    start_frame();
    send(8'h01);
    send(8'h02);
    repeat (4) tick();
    start_frame();
    check("t4_overflow_cleared", 32'(overflow), 32'd0);
    repeat (3) tick();
    stall = 1'b0;
    repeat (3) tick();
    check("t4_stop_addr_kept", 32'(stop_addr), 32'd9);
    exp_wr(0, 16'h0506);
    send(8'h05);
    send(8'h06);
    end_frame();
    wait_done(4);
    check("t4_stop_addr", 32'(stop_addr), 32'd1);

    // 5: address limit with 4-bit addresses, 40 bytes paced to the write rate
    lat = 0;
    for (int k = 0; k < 16; k++) exp_wr(k, {8'(8'h80 + 2*k), 8'(8'h81 + 2*k)});
    start_frame();
    for (int k = 0; k < 20; k++) begin
      send(8'(8'h80 + 2*k));
      send(8'(8'h81 + 2*k));
      tick();
    end
    end_frame();
    wait_done(5);
    repeat (10) tick();
    check("t5_overflow",  32'(overflow),  32'd1);
    check("t5_stop_addr", 32'(stop_addr), 32'd15);
    check("t5_no_extra",  32'(sb.size()), 32'd0);
`ifdef PIXEL_INPUT_STATS_EN
    check("t5_dropped_words", 32'(dropped_words), 32'd4);
`endif

    // 6: reset while waiting on the SRAM, then a clean frame
    lat   = 2;
    stall = 1'b1;
    exp_wr(0, 16'h7788);
    start_frame();
    send(8'h77);
    send(8'h88);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals();
`ifdef PIXEL_INPUT_STATS_EN
    check("t6_dropped_words", 32'(dropped_words), 32'd0);
`endif
    stall = 1'b0;
    check("t6_pending_flushed", 32'(sb.size()), 32'd0);
    exp_wr(0, 16'h1122);
    exp_wr(1, 16'h3344);
    start_frame();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    end_frame();
    wait_done(6);
    check("t6_stop_addr", 32'(stop_addr), 32'd2);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
